// File: rtl/pc_gen.sv
// pc_gen: instruction fetch address generator.
//
// Holds the fetch PC and the instruction memory chip enable. Once out of
// reset the PC advances by INST_BYTES whenever the IF stage is not stalled
// and the instruction memory accepts the request. A flush redirects to
// new_pc unconditionally. A branch that arrives while the fetch cannot
// advance is parked in a one-entry pending register and replayed on the
// next advance.
//
// Ports:
//   clk                      clock, rising edge
//   rst                      synchronous active-high reset
//   stall[5:0]               pipeline stall vector; only stall[0] (IF) used
//   branch_flag_i            redirect request to branch_target_address_i
//   branch_target_address_i  branch target
//   flush                    exception redirect to new_pc
//   new_pc                   exception handler entry
//   if_ready_i               instruction memory accepts the request
//   pc                       registered fetch address
//   ce                       registered instruction memory chip enable
//   pend_valid_o             a deferred branch target is held
//   adel_o                   current fetch address is misaligned
module pc_gen #(
  parameter int unsigned              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC   = '0,
  parameter int unsigned              INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              if_ready_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              pend_valid_o,
  output logic              adel_o
);

  localparam int unsigned       AL  = $clog2(INST_BYTES);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);

  logic              adv;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] pend_addr_n;
  logic              pend_valid_n;

  // Only the IF stage stall bit matters here.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign adv = ce & ~stall[0] & if_ready_i;

  always_comb begin
    pc_n         = pc;
    pend_addr_n  = pend_addr;
    pend_valid_n = pend_valid_o;
    if (!ce) begin
      pc_n         = RESET_PC;
      pend_valid_n = 1'b0;
    end else if (flush) begin
      pc_n         = new_pc;
      pend_valid_n = 1'b0;
    end else if (adv) begin
      // Live branch beats a parked one; either way the pending slot empties.
      if (branch_flag_i)     pc_n = branch_target_address_i;
      else if (pend_valid_o) pc_n = pend_addr;
      else                   pc_n = pc + INC;
      pend_valid_n = 1'b0;
    end else if (branch_flag_i) begin
      pend_addr_n  = branch_target_address_i;
      pend_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce           <= 1'b0;
      pc           <= RESET_PC;
      pend_valid_o <= 1'b0;
      pend_addr    <= '0;
    end else begin
      ce           <= 1'b1;
      pc           <= pc_n;
      pend_valid_o <= pend_valid_n;
      pend_addr    <= pend_addr_n;
    end
  end

  generate
    if (AL == 0) begin : g_no_align
      assign adel_o = 1'b0;
    end else begin : g_align
      assign adel_o = ce & (pc[AL-1:0] != '0);
    end
  endgenerate

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        flush;
  logic [31:0] new_pc;
  logic        if_ready_i;
  logic [31:0] pc;
  logic        ce;
  logic        pend_valid_o;
  logic        adel_o;

  pc_gen #(.ADDR_W(32), .RESET_PC(RPC), .INST_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i), .flush(flush),
    .new_pc(new_pc), .if_ready_i(if_ready_i), .pc(pc), .ce(ce),
    .pend_valid_o(pend_valid_o), .adel_o(adel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        adel;
    bit          chk_pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: what the fetch unit should hold after each edge.
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_pend;
  logic [31:0] m_paddr;

  task automatic do_cycle(input bit r, input logic [5:0] st, input bit br,
                          input logic [31:0] bt, input bit fl,
                          input logic [31:0] np, input bit rdy);
    exp_t e;
    bit   adv;
    rst = r; stall = st; branch_flag_i = br; branch_target_address_i = bt;
    flush = fl; new_pc = np; if_ready_i = rdy;
    e.chk_pc = 1'b1;
    if (r) begin
      // PC value on the reset edge itself is only pinned down one edge later.
      e.chk_pc = !m_ce;
      m_ce = 1'b0; m_pend = 1'b0; m_pc = RPC;
    end else if (!m_ce) begin
      m_ce = 1'b1; m_pc = RPC; m_pend = 1'b0;
    end else begin
      adv = !st[0] && rdy;
      if (fl) begin
        m_pc = np; m_pend = 1'b0;
      end else if (adv) begin
        if (br)          m_pc = bt;
        else if (m_pend) m_pc = m_paddr;
        else             m_pc = m_pc + 32'd4;
        m_pend = 1'b0;
      end else if (br) begin
        m_pend = 1'b1; m_paddr = bt;
      end
    end
    e.pc   = m_pc;
    e.ce   = m_ce;
    e.pend = m_pend;
    e.adel = m_ce && (m_pc % 4 != 0);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 6'd0, 0, 32'd0, 0, 32'd0, 1);
  endtask

  // Monitor: every edge produces a new output set to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ce !== e.ce) begin
          failures++;
          $display("FAIL ce: got %b expected %b at %0t", ce, e.ce, $time);
        end
        checks++;
        if (pend_valid_o !== e.pend) begin
          failures++;
          $display("FAIL pend_valid_o: got %b expected %b at %0t", pend_valid_o, e.pend, $time);
        end
        if (e.chk_pc) begin
          checks++;
          if (pc !== e.pc) begin
            failures++;
            $display("FAIL pc: got %h expected %h at %0t", pc, e.pc, $time);
          end
          checks++;
          if (adel_o !== e.adel) begin
            failures++;
            $display("FAIL adel_o: got %b expected %b at %0t", adel_o, e.adel, $time);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0]  st;
    logic [31:0] t;
    m_ce = 1'b1; m_pend = 1'b0; m_pc = RPC; m_paddr = '0;
    rst = 1'b1; stall = '0; branch_flag_i = 1'b0; branch_target_address_i = '0;
    flush = 1'b0; new_pc = '0; if_ready_i = 1'b1;

    // Reset then sequential fetch from RESET_PC.
    do_cycle(1, 6'd0, 0, 0, 0, 0, 1);
    do_cycle(1, 6'd0, 0, 0, 0, 0, 1);
    idle(4);

    // Branch parked during stall, replayed on release.
    do_cycle(0, 6'd0, 0, 0, 1, 32'h200, 1);
    do_cycle(0, 6'd1, 1, 32'h400, 0, 0, 1);
    do_cycle(0, 6'd1, 0, 0, 0, 0, 1);
    do_cycle(0, 6'd1, 0, 0, 0, 0, 1);
    idle(3);

    // Flush during stall with a pending target discards it.
    do_cycle(0, 6'd1, 1, 32'h400, 0, 0, 1);
    do_cycle(0, 6'd1, 0, 0, 1, 32'h80, 1);
    do_cycle(0, 6'd1, 0, 0, 0, 0, 1);
    idle(2);

    // Memory not ready holds pc; later branch overwrites pending.
    do_cycle(0, 6'd0, 0, 0, 1, 32'h10, 1);
    do_cycle(0, 6'd0, 0, 0, 0, 0, 0);
    do_cycle(0, 6'd0, 1, 32'h500, 0, 0, 0);
    do_cycle(0, 6'd0, 1, 32'h600, 0, 0, 0);
    idle(2);
    // Live branch beats pending one on advance.
    do_cycle(0, 6'd1, 1, 32'h700, 0, 0, 1);
    do_cycle(0, 6'd0, 1, 32'h900, 0, 0, 1);
    idle(1);

    // Wrap and misaligned target.
    do_cycle(0, 6'd0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    idle(2);
    do_cycle(0, 6'd0, 1, 32'h1002, 0, 0, 1);
    do_cycle(0, 6'd1, 0, 0, 0, 0, 1);
    idle(1);

    // Reset while pending held and stalled.
    do_cycle(0, 6'd1, 1, 32'h3000, 0, 0, 1);
    do_cycle(1, 6'd1, 0, 0, 0, 0, 1);
    do_cycle(0, 6'd1, 1, 32'h4000, 1, 32'h8, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      st = 6'($urandom);
      st[0] = ($urandom_range(0, 3) == 0);
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8 | (t & 32'h4);
      do_cycle($urandom_range(0, 49) == 0, st, $urandom_range(0, 4) == 0, t,
               $urandom_range(0, 14) == 0, $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 3) != 0);
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
